// File: rtl/uimm_issue_if.sv
// Handshake bundle between decode, the U-type sequencer and the regfile write arbiter.
// Both the decode->sequencer and the sequencer->writeback channels travel together.
interface uimm_issue_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  modport master (
    output in_valid, in_inst, in_pc, wb_ready,
    input  in_ready, wb_valid, wb_rd, wb_data
  );

  modport slave (
    input  in_valid, in_inst, in_pc, wb_ready,
    output in_ready, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/uimm_issue_seq.sv
// U-type (LUI/AUIPC) execute sequencer: accept one decoded instruction, compute the
// U-immediate result in a CALC cycle, then hold it for the regfile write arbiter.
module uimm_issue_seq #(
  parameter int XLEN      = 64,
  parameter int PC_OFFSET = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  uimm_issue_if.slave      bus,
  input  logic             flush,
  output logic             illegal,
  output logic             busy,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  function automatic logic signed [XLEN-1:0] u_imm(input logic [31:0] inst);
    logic signed [31:0] imm32;
    imm32 = {inst[31:12], 12'h000};
    return XLEN'(imm32);
  endfunction

  function automatic logic signed [XLEN-1:0] wrap_add(
    input logic signed [XLEN-1:0] a,
    input logic signed [XLEN-1:0] b
  );
    return a + b;
  endfunction

  logic [1:0]             state;
  logic                   accept;
  logic                   legal;
  logic [31:0]            inst_p0;
  logic signed [XLEN-1:0] pc_p0;
  logic signed [XLEN-1:0] imm_p1;
  logic signed [XLEN-1:0] calc_p1;

  // in_ready is forced low while reset is held, even though state already reads IDLE.
  assign bus.in_ready = (state == IDLE) && !flush && !rst;
  assign busy         = (state != IDLE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign legal        = (bus.in_inst[6:0] == OP_LUI) || (bus.in_inst[6:0] == OP_AUIPC);

  // Stage p0: capture the accepted instruction and pc.
  always_ff @(posedge clk) begin
    if (accept && legal) begin
      inst_p0 <= bus.in_inst;
      pc_p0   <= bus.in_pc;
    end
  end

  // Stage p1: U-immediate and AUIPC sum (decode hands over the already-advanced pc).
  always_comb begin
    imm_p1  = u_imm(inst_p0);
    calc_p1 = imm_p1;
    if (inst_p0[6:0] == OP_AUIPC) begin
      calc_p1 = wrap_add(pc_p0 - XLEN'(PC_OFFSET), imm_p1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bus.wb_valid <= 1'b0;
      bus.wb_rd    <= 5'd0;
      bus.wb_data  <= '0;
      illegal      <= 1'b0;
      retire_cnt   <= '0;
    end else begin
      illegal <= 1'b0;
      if (flush) begin
        state        <= IDLE;
        bus.wb_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              if (legal) state <= CALC;
              else       illegal <= 1'b1;
            end
          end
          CALC: begin
            bus.wb_rd   <= inst_p0[11:7];
            bus.wb_data <= calc_p1;
            if (inst_p0[11:7] == 5'd0) begin
              retire_cnt <= retire_cnt + CNT_W'(1);
              state      <= IDLE;
            end else begin
              bus.wb_valid <= 1'b1;
              state        <= WRITE;
            end
          end
          WRITE: begin
            if (bus.wb_ready) begin
              bus.wb_valid <= 1'b0;
              retire_cnt   <= retire_cnt + CNT_W'(1);
              state        <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uimm_issue_seq.sv
// Directed bench for uimm_issue_seq: LUI/AUIPC results, sign extension, stall, rd=x0,
// illegal opcode, flush in each state, async reset in CALC and retire counter wrap.
module tb_uimm_issue_seq;
  localparam int XLEN  = 64;
  localparam int CNT_W = 3;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             illegal;
  logic             busy;
  logic [CNT_W-1:0] retire_cnt;
  int               checks;
  int               errors;

  uimm_issue_if #(.XLEN(XLEN)) bus ();

  uimm_issue_seq #(.XLEN(XLEN), .PC_OFFSET(4), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .flush      (flush),
    .illegal    (illegal),
    .busy       (busy),
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single accepting edge, then scramble the inputs.
  task automatic issue(input logic [31:0] inst, input logic [63:0] pc);
    bus.in_valid = 1'b1;
    bus.in_inst  = inst;
    bus.in_pc    = pc;
    step();
    bus.in_valid = 1'b0;
    bus.in_inst  = 32'hDEAD_BEEF;
    bus.in_pc    = 64'h5555_5555_5555_5555;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_inst  = 32'h0;
    bus.in_pc    = 64'h0;
    bus.wb_ready = 1'b1;
    repeat (2) step();

    chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_busy",     64'(busy),         64'd0);
    chk("rst_wb_data",  bus.wb_data,       64'd0);
    chk("rst_cnt",      64'(retire_cnt),   64'd0);
    chk("rst_illegal",  64'(illegal),      64'd0);
    rst = 1'b0;

    // LUI x5, 0x12345
    bus.in_valid = 1'b1;
    bus.in_inst  = 32'h1234_52B7;
    bus.in_pc    = 64'h100;
    #1;
    chk("t1_in_ready_idle", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    bus.in_inst  = 32'hDEAD_BEEF;
    chk("t1_busy_calc",     64'(busy),         64'd1);
    chk("t1_in_ready_calc", 64'(bus.in_ready), 64'd0);
    chk("t1_no_valid_yet",  64'(bus.wb_valid), 64'd0);
    step();
    chk("t1_wb_valid", 64'(bus.wb_valid), 64'd1);
    chk("t1_wb_rd",    64'(bus.wb_rd),    64'd5);
    chk("t1_wb_data",  bus.wb_data,       64'h0000_0000_1234_5000);
    step();
    chk("t1_valid_drop", 64'(bus.wb_valid), 64'd0);
    chk("t1_cnt",        64'(retire_cnt),   64'd1);
    chk("t1_idle",       64'(busy),         64'd0);

    // LUI x1, 0x80000: sign extension from bit 31
    issue(32'h8000_00B7, 64'h0);
    step();
    chk("t2_wb_rd",   64'(bus.wb_rd), 64'd1);
    chk("t2_wb_data", bus.wb_data,    64'hFFFF_FFFF_8000_0000);
    step();
    chk("t2_cnt", 64'(retire_cnt), 64'd2);

    // AUIPC x3, 0x1 at pc 0x8000_0000
    issue(32'h0000_1197, 64'h8000_0004);
    step();
    chk("t3_wb_rd",   64'(bus.wb_rd), 64'd3);
    chk("t3_wb_data", bus.wb_data,    64'h0000_0000_8000_1000);
    step();
    chk("t3_cnt", 64'(retire_cnt), 64'd3);

    // AUIPC x3, 0xFFFFF at pc 0, with a five-cycle writeback stall
    bus.wb_ready = 1'b0;
    issue(32'hFFFF_F197, 64'h4);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid",    64'(bus.wb_valid), 64'd1);
      chk("t4_hold_data",     bus.wb_data,       64'hFFFF_FFFF_FFFF_F000);
      chk("t4_hold_rd",       64'(bus.wb_rd),    64'd3);
      chk("t4_hold_in_ready", 64'(bus.in_ready), 64'd0);
      chk("t4_hold_cnt",      64'(retire_cnt),   64'd3);
      step();
    end
    bus.wb_ready = 1'b1;
    step();
    chk("t4_valid_drop", 64'(bus.wb_valid), 64'd0);
    chk("t4_cnt",        64'(retire_cnt),   64'd4);

    // LUI x0: retires without a write
    issue(32'h1234_5037, 64'h0);
    chk("t5_busy_calc", 64'(busy), 64'd1);
    step();
    chk("t5_no_valid", 64'(bus.wb_valid), 64'd0);
    chk("t5_idle",     64'(busy),         64'd0);
    chk("t5_cnt",      64'(retire_cnt),   64'd5);

    // ADDI: illegal pulse for one cycle
    issue(32'h0010_0093, 64'h0);
    chk("t6_illegal",  64'(illegal),      64'd1);
    chk("t6_no_valid", 64'(bus.wb_valid), 64'd0);
    chk("t6_idle",     64'(busy),         64'd0);
    step();
    chk("t6_illegal_clr", 64'(illegal),    64'd0);
    chk("t6_cnt",         64'(retire_cnt), 64'd5);

    // flush in IDLE blocks the transfer
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_inst  = 32'h1234_52B7;
    #1;
    chk("f_idle_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("f_idle_busy", 64'(busy), 64'd0);

    // flush in WRITE beats a same-cycle wb_ready
    bus.wb_ready = 1'b0;
    issue(32'h1234_52B7, 64'h0);
    step();
    chk("f_write_valid", 64'(bus.wb_valid), 64'd1);
    flush        = 1'b1;
    bus.wb_ready = 1'b1;
    step();
    flush = 1'b0;
    chk("f_write_drop", 64'(bus.wb_valid), 64'd0);
    chk("f_write_cnt",  64'(retire_cnt),   64'd5);
    chk("f_write_idle", 64'(busy),         64'd0);

    // flush in CALC discards the instruction
    issue(32'h0000_1197, 64'h1000);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("f_calc_valid", 64'(bus.wb_valid), 64'd0);
    chk("f_calc_idle",  64'(busy),         64'd0);
    step();
    chk("f_calc_cnt", 64'(retire_cnt), 64'd5);

    // async reset in CALC
    issue(32'h1234_52B7, 64'h0);
    rst = 1'b1;
    #1;
    chk("r_wb_data", bus.wb_data,       64'd0);
    chk("r_wb_rd",   64'(bus.wb_rd),    64'd0);
    chk("r_cnt",     64'(retire_cnt),   64'd0);
    chk("r_busy",    64'(busy),         64'd0);
    chk("r_ready",   64'(bus.in_ready), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("r_valid_after", 64'(bus.wb_valid), 64'd0);

    // retire counter wraps 7 -> 0
    for (int i = 0; i < 7; i++) begin
      issue(32'h0000_0037, 64'h0);
      step();
    end
    chk("w_cnt7", 64'(retire_cnt), 64'd7);
    issue(32'h0000_0037, 64'h0);
    step();
    chk("w_cnt_wrap", 64'(retire_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
